fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier that consumes operands in the team's float format: sign, 8-bit exponent, 23-bit fraction.
- Produces a rounded float result and exception flags.
- Sits downstream of the floating-point package and its component constructor, and beside the N-bit divider.
- Built around a shift-add mantissa datapath with valid/ready handshakes on input and output.

Parameters:
- BITS_PER_CYCLE, default 1: multiplier bits retired per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8, 12 and 24; any other value is an elaboration error.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands a/b valid.
- in_ready, output, 1: block can accept operands.
- a, input, 32: operand {sign[31], exponent[30:23], fraction[22:0]}.
- b, input, 32: operand, same layout.
- out_valid, output, 1: result/flags valid.
- out_ready, input, 1: consumer accepts result.
- result, output, 32: product, same layout.
- flags, output, 4: {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. reset_n low forces state=IDLE, in_ready=0, out_valid=0, result=0, flags=0 immediately, regardless of clock. An in-flight operation is discarded. in_ready rises on the first clock edge after reset_n deasserts.
- States and transitions:
  - IDLE (in_ready=1): accept on in_valid&&in_ready. Operands are registered and the classifier runs. A special case goes to DONE; otherwise go to MUL.
  - MUL: 24/BITS_PER_CYCLE cycles of shift-add on the 24-bit significands (hidden 1 restored), producing a 48-bit product. Exponent sum = ea+eb-127, held in a 10-bit signed register.
  - NORM (1 cycle): if product[47]=1, shift right by 1 and add 1 to the exponent. guard = next bit below the 24-bit kept significand; sticky = OR of all lower bits.
  - ROUND (1 cycle): round-to-nearest-even. Round up when guard && (sticky || lsb). A carry-out of the rounded significand sets it to 1.0 and adds 1 to the exponent. inexact = guard||sticky.
  - DONE: out_valid=1. result and flags are held stable until out_ready. On out_ready, go to IDLE next cycle (out_valid drops, in_ready rises). No overlap: in_ready=0 in every state except IDLE.
- Range checks after rounding:
  - exp>=255: result = sign|0x7F800000; overflow=1, inexact=1.
  - exp<=0: result = signed zero; underflow=1, inexact=1. No denormal outputs (flush-to-zero).
- Latency:
  - Normal path: out_valid rises 24/BITS_PER_CYCLE+2 cycles after the accept edge (26 for BITS_PER_CYCLE=1).
  - Special path: out_valid rises 1 cycle after accept.
- Special cases, priority top-down. The result sign is a_sign^b_sign except for NaN.
  - Either operand NaN → 0x7FC00000. invalid=1 only if that NaN is signalling (fraction[22]=0).
  - inf × zero → 0x7FC00000, invalid=1.
  - inf × finite-nonzero → signed inf, flags=0.
  - zero or denormal operand (exp=0) → signed zero, flags=0. Denormal inputs are treated as zero.
- Backpressure: out_ready may stay low indefinitely; outputs are frozen, and in_valid is ignored while busy.

Decomposition:
- Package additions to the shared floating-point package:
  - BIAS=127, MANT_BITS=24, FP_BITS=32, QNAN=32'h7FC00000.
  - Packed typedef fp_word_t with the 32-bit layout.
  - Packed struct fp_flags_t {invalid, overflow, underflow, inexact}.
  - Enum fp_mul_state_t {IDLE, MUL, NORM, ROUND, DONE}.
  - Helper functions packing/unpacking fp_word_t to and from float.
- Sub-module fp_classify, combinational: per-operand is_zero, is_inf, is_nan, is_snan. It is reused later by the adder and divider.

Test Plan (BITS_PER_CYCLE=1 unless stated):
- a=0x3FC00000 (1.5), b=0x40000000 (2.0) → after 26 cycles result=0x40400000, flags=0, in_ready low throughout.
- Tie rounding: a=0x3F800001, b=0x3FC00000 → result=0x3FC00002, inexact=1 only. Repeat with BITS_PER_CYCLE=8: same result after 5 cycles.
- Overflow: a=0x7F000000, b=0x7F000000 → result=0x7F800000, overflow=1, inexact=1. Underflow: a=0x00800000, b=0x00800000 → result=0x00000000, underflow=1, inexact=1.
- Specials at 1-cycle latency:
  - 0xFF800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F800001 (sNaN) × 0x3F800000 → 0x7FC00000, invalid=1.
  - 0x80000000 × 0x40000000 → 0x80000000, flags=0.
- Backpressure: out_ready low for 10 cycles after out_valid → result/flags unchanged, in_valid pulses ignored. out_ready high → IDLE next cycle, then the next operand pair is accepted.
- Reset_n pulsed low mid-MUL (cycle 10) → out_valid=0, result=0 asynchronously. Post-reset 1.0×1.0 (0x3F800000 each) → 0x3F800000 with no residue from the aborted operation.

Source files
------------

// File: rtl/fp_mul_seq_pkg.sv
// Shared single-precision float definitions used by the sequential multiplier
// and its classifier (and later by the adder and divider).
package fp_mul_seq_pkg;

  localparam int BIAS      = 127;
  localparam int MANT_BITS = 24;
  localparam int FP_BITS   = 32;
  localparam logic [FP_BITS-1:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_word_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    NORM,
    ROUND,
    DONE
  } fp_mul_state_t;

  function automatic fp_word_t fp_unpack(input logic [FP_BITS-1:0] bits);
    return fp_word_t'(bits);
  endfunction

  function automatic logic [FP_BITS-1:0] fp_pack(input fp_word_t w);
    return {w.sign, w.exp, w.frac};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals report as zero since the
// arithmetic blocks flush them.
module fp_classify
  import fp_mul_seq_pkg::*;
(
  input  fp_word_t x,
  output logic     is_zero,
  output logic     is_inf,
  output logic     is_nan,
  output logic     is_snan
);

  logic exp_max;
  logic frac_zero;

  always_comb begin
    exp_max   = &x.exp;
    frac_zero = (x.frac == 23'h0);
    is_zero   = (x.exp == 8'h00);
    is_inf    = exp_max && frac_zero;
    is_nan    = exp_max && !frac_zero;
    is_snan   = is_nan && !x.frac[22];
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle single-precision multiplier: shift-add significand product,
// then normalise, round-to-nearest-even and range check.
module fp_mul_seq
  import fp_mul_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam bit BPC_LEGAL = (BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
                             (BITS_PER_CYCLE == 3) || (BITS_PER_CYCLE == 4) ||
                             (BITS_PER_CYCLE == 6) || (BITS_PER_CYCLE == 8) ||
                             (BITS_PER_CYCLE == 12) || (BITS_PER_CYCLE == 24);
  localparam int MUL_CYCLES = MANT_BITS / BITS_PER_CYCLE;
  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES);
  localparam logic signed [9:0] EXP_BIAS = 10'(BIAS);

  generate
    if (!BPC_LEGAL) begin : g_bad_bpc
      $error("fp_mul_seq: BITS_PER_CYCLE=%0d unsupported", BITS_PER_CYCLE);
    end
  endgenerate

  fp_mul_state_t state, next_state;

  fp_word_t  op_a, op_b;
  fp_word_t  result_q;
  fp_flags_t flags_q;
  logic      in_ready_q, out_valid_q;
  logic      res_sign;

  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  logic      special;
  fp_word_t  special_word;
  fp_flags_t special_flags;

  logic [4:0]               mul_cnt;
  logic [MANT_BITS-1:0]     mcand;
  logic [2*MANT_BITS-1:0]   prod, prod_step;
  logic [MANT_BITS:0]       step_sum;
  logic signed [9:0]        exp_q;
  logic [MANT_BITS-1:0]     sig_q;
  logic                     guard_q, sticky_q;

  logic                 round_up;
  logic [MANT_BITS:0]   sig_rnd;
  logic [MANT_BITS-1:0] sig_fin;
  logic signed [9:0]    exp_rnd;
  fp_word_t             rnd_word;
  fp_flags_t            rnd_flags;

  fp_classify u_class_a (
    .x       (op_a),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .is_snan (a_snan)
  );

  fp_classify u_class_b (
    .x       (op_b),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .is_snan (b_snan)
  );

  assign res_sign  = op_a.sign ^ op_b.sign;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = fp_pack(result_q);
  assign flags     = flags_q;

  // Special-case priority: NaN, inf*zero, inf, zero/denormal.
  always_comb begin
    special       = 1'b1;
    special_word  = fp_unpack({res_sign, 31'h0});
    special_flags = '0;
    if (a_nan || b_nan) begin
      special_word          = fp_unpack(QNAN);
      special_flags.invalid = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      special_word          = fp_unpack(QNAN);
      special_flags.invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      special_word = fp_unpack({res_sign, 8'hFF, 23'h0});
    end else if (a_zero || b_zero) begin
      special_word = fp_unpack({res_sign, 31'h0});
    end else begin
      special = 1'b0;
    end
  end

  // Retire BITS_PER_CYCLE multiplier bits: add multiplicand on a set LSB,
  // then shift the {accumulator, multiplier} pair right.
  always_comb begin
    prod_step = prod;
    step_sum  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_sum  = {1'b0, prod_step[2*MANT_BITS-1:MANT_BITS]} +
                  (prod_step[0] ? {1'b0, mcand} : {(MANT_BITS+1){1'b0}});
      prod_step = {step_sum, prod_step[MANT_BITS-1:1]};
    end
  end

  always_comb begin
    round_up  = guard_q && (sticky_q || sig_q[0]);
    sig_rnd   = {1'b0, sig_q} + {{MANT_BITS{1'b0}}, round_up};
    sig_fin   = sig_rnd[MANT_BITS-1:0];
    exp_rnd   = exp_q;
    if (sig_rnd[MANT_BITS]) begin
      sig_fin = {1'b1, {(MANT_BITS-1){1'b0}}};
      exp_rnd = exp_q + 10'sd1;
    end
    rnd_word          = fp_unpack({res_sign, exp_rnd[7:0], sig_fin[22:0]});
    rnd_flags         = '0;
    rnd_flags.inexact = guard_q || sticky_q;
    if (exp_rnd >= 10'sd255) begin
      rnd_word            = fp_unpack({res_sign, 8'hFF, 23'h0});
      rnd_flags.overflow  = 1'b1;
      rnd_flags.inexact   = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      rnd_word            = fp_unpack({res_sign, 31'h0});
      rnd_flags.underflow = 1'b1;
      rnd_flags.inexact   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Specials are resolved on the first MUL cycle, once the operands are registered.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (in_valid && in_ready_q) next_state = MUL;
      MUL: begin
        if (mul_cnt == MUL_CNT_INIT && special) next_state = DONE;
        else if (mul_cnt == 5'd1)               next_state = NORM;
      end
      NORM:  next_state = ROUND;
      ROUND: next_state = DONE;
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_a        <= '0;
      op_b        <= '0;
      mcand       <= '0;
      prod        <= '0;
      mul_cnt     <= '0;
      exp_q       <= '0;
      sig_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_a    <= fp_unpack(a);
            op_b    <= fp_unpack(b);
            mcand   <= {1'b1, a[22:0]};
            prod    <= {{MANT_BITS{1'b0}}, 1'b1, b[22:0]};
            mul_cnt <= MUL_CNT_INIT;
            exp_q   <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - EXP_BIAS;
          end
        end
        MUL: begin
          prod    <= prod_step;
          mul_cnt <= mul_cnt - 5'd1;
          if (next_state == DONE) begin
            result_q <= special_word;
            flags_q  <= special_flags;
          end
        end
        NORM: begin
          if (prod[2*MANT_BITS-1]) begin
            sig_q    <= prod[47:24];
            guard_q  <= prod[23];
            sticky_q <= |prod[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            sig_q    <= prod[46:23];
            guard_q  <= prod[22];
            sticky_q <= |prod[21:0];
          end
        end
        ROUND: begin
          result_q <= rnd_word;
          flags_q  <= rnd_flags;
        end
        default: ;
      endcase
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed corner cases plus random normal
// operands checked against an integer reference multiply.
module tb_fp_mul_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [31:0] a8, b8, result8;
  logic [3:0]  flags8;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  fp_mul_seq #(.BITS_PER_CYCLE(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_mul_seq #(.BITS_PER_CYCLE(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flags(flags8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  // Reference: exact 48-bit product, rounding decided by comparing the
  // discarded remainder against half an ulp.
  function automatic logic [35:0] modelMul(input logic [31:0] x, input logic [31:0] y);
    logic s, nx, ny, ix, iy, zx, zy, up;
    longint unsigned p, kept, rem, half;
    int e, sh;
    logic [3:0]  f;
    logic [31:0] r;
    s  = x[31] ^ y[31];
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:23] == 8'h00);
    zy = (y[30:23] == 8'h00);
    f  = 4'h0;
    if (nx || ny) begin
      r    = 32'h7FC00000;
      f[3] = (nx && !x[22]) || (ny && !y[22]);
    end else if ((ix && zy) || (zx && iy)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (ix || iy) begin
      r = {s, 31'h7F800000};
    end else if (zx || zy) begin
      r = {s, 31'h0};
    end else begin
      p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e  = int'(x[30:23]) + int'(y[30:23]) - 127;
      sh = p[47] ? 24 : 23;
      if (p[47]) e++;
      kept = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && kept[0]);
      kept = kept + 64'(up);
      if (kept == 64'h1000000) begin kept = 64'h800000; e++; end
      f[0] = (rem != 0);
      if (e >= 255) begin
        r = {s, 31'h7F800000}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0011;
      end else begin
        r = {s, 8'(e), kept[22:0]};
      end
    end
    return {f, r};
  endfunction

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] want_res, input logic [3:0] want_flg,
                               input int want_lat);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin @(negedge clock); n++; end
    checkOutput("accept_ready", {31'h0, in_ready}, 32'h1);
    a = x; b = y; in_valid = 1'b1;
    e.res = want_res; e.flg = want_flg; e.lat = want_lat;
    sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic collectOutput(input string tag, input int hold);
    exp_t e;
    int   lat = 0;
    logic busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (in_ready) busy_ok = 1'b0;
    end
    e = sb.pop_front();
    checkOutput({tag, "_res"}, result, e.res);
    checkOutput({tag, "_flags"}, {28'h0, flags}, {28'h0, e.flg});
    checkOutput({tag, "_lat"}, 32'(lat), 32'(e.lat));
    checkOutput({tag, "_busy"}, {31'h0, busy_ok}, 32'h1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        in_valid = (i % 3 == 0);
        a = 32'h40000000; b = 32'h40400000;
      end
      @(negedge clock);
      in_valid = 1'b0;
      checkOutput({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
      checkOutput({tag, "_hold_res"}, result, e.res);
      checkOutput({tag, "_hold_flags"}, {28'h0, flags}, {28'h0, e.flg});
      checkOutput({tag, "_hold_ready"}, {31'h0, in_ready}, 32'h0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, {31'h0, out_valid}, 32'h0);
    checkOutput({tag, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [35:0] m;
    int lat, n;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_flags", {28'h0, flags}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1 checkOutput("rel_in_ready_low", {31'h0, in_ready}, 32'h0);
    @(posedge clock); #1;
    checkOutput("rel_in_ready_high", {31'h0, in_ready}, 32'h1);

    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26); collectOutput("mul_1p5x2", 0);
    applyStimulus(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26); collectOutput("tie_even", 0);
    applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26); collectOutput("overflow", 0);
    applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26); collectOutput("underflow", 0);
    applyStimulus(32'hFF800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);  collectOutput("inf_x_zero", 0);
    applyStimulus(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);  collectOutput("snan", 0);
    applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);  collectOutput("qnan", 0);
    applyStimulus(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1);  collectOutput("neg_zero", 0);
    applyStimulus(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1);  collectOutput("inf_x_neg", 0);
    applyStimulus(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 1);  collectOutput("denorm", 0);
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26); collectOutput("backpressure", 10);
    applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 26); collectOutput("after_bp", 0);

    for (int i = 0; i < 8; i++) begin
      x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      m = modelMul(x, y);
      applyStimulus(x, y, m[31:0], m[35:32], 26);
      collectOutput($sformatf("rand%0d", i), 0);
    end

    n = 0;
    while (!in_ready8 && n < 50) begin @(negedge clock); n++; end
    a8 = 32'h3F800001; b8 = 32'h3FC00000; in_valid8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin @(posedge clock); #1; lat++; end
    checkOutput("bpc8_res", result8, 32'h3FC00002);
    checkOutput("bpc8_flags", {28'h0, flags8}, 32'h1);
    checkOutput("bpc8_lat", 32'(lat), 32'd5);
    @(negedge clock); out_ready8 = 1'b1;
    @(posedge clock); #1; out_ready8 = 1'b0;

    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    repeat (10) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("abort_result", result, 32'h0);
    checkOutput("abort_flags", {28'h0, flags}, 32'h0);
    checkOutput("abort_in_ready", {31'h0, in_ready}, 32'h0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("abort_rel_ready", {31'h0, in_ready}, 32'h1);
    applyStimulus(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26); collectOutput("post_reset", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
